wave_sequencer: RTL and testbench

- Controller for the 8-bit waveform DAC datapath. Sequences a programmable ramp generator: clock prescale, amplitude (top), step size, waveform mode, and burst length.
- Takes configuration through a valid/ready handshake into a shadow register. In RUN, that shadow is applied only on period boundaries, so the output never glitches mid-period.
- Sits between the control/register logic and the DAC output register.

---
 rtl/wave_seq_pkg.sv | 43 ++++
 rtl/wave_ramp_core.sv | 105 ++++++++++
 rtl/wave_sequencer.sv | 139 +++++++++++++
 tb/tb_wave_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wave_seq_pkg.sv
// Shared types and constants for the waveform sequencer and its ramp core.
package wave_seq_pkg;

    localparam int unsigned DataW = 8;
    localparam int unsigned DivW  = 16;
    localparam int unsigned CntW  = 16;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    typedef enum logic [1:0] {
        MODE_SAW,
        MODE_TRI,
        MODE_SQR,
        MODE_RSV
    } mode_t;

    typedef struct packed {
        logic [DivW-1:0]  div;
        logic [DataW-1:0] top;
        logic [DataW-1:0] step;
        mode_t            mode;
        logic [CntW-1:0]  cycles;
    } wave_cfg_t;

    // Power-on configuration: full-scale saw, unit step, no prescale, continuous.
    localparam wave_cfg_t CfgReset = '{
        div:    '0,
        top:    '1,
        step:   DataW'(1),
        mode:   MODE_SAW,
        cycles: '0
    };

    // A zero step would stall the ramp forever, so it is promoted to one.
    function automatic logic [DataW-1:0] eff_step(input logic [DataW-1:0] s);
        return (s == '0) ? DataW'(1) : s;
    endfunction

endpackage

// File: rtl/wave_ramp_core.sv
// Prescaler, ramp accumulator and per-mode shaping; emits one registered sample per tick.
module wave_ramp_core
    import wave_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  wave_cfg_t        cfg,
    input  logic             clear,
    input  logic             run,
    output logic [DataW-1:0] sample,
    output logic             sample_valid,
    output logic             period_end
);

    logic [DivW-1:0]  pre_q, pre_d;
    logic [DataW-1:0] acc_q, acc_d;
    logic [DataW-1:0] sample_q, sample_d;
    logic             dir_q, dir_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic             tick;
    logic [DataW-1:0] step;
    logic [DataW:0]   sum;
    logic             bounce;
    logic             unused_cfg;

    assign step       = eff_step(cfg.step);
    assign tick       = run && (pre_q == cfg.div);
    assign sum        = {1'b0, acc_q} + {1'b0, step};
    assign bounce     = (cfg.mode == MODE_TRI) || (cfg.mode == MODE_SQR);
    assign unused_cfg = ^cfg.cycles;

    // Next-state for prescaler, accumulator, direction and the registered sample.
    always_comb begin
        pre_d    = pre_q;
        acc_d    = acc_q;
        dir_d    = dir_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        pend_d   = 1'b0;
        if (clear) begin
            pre_d    = '0;
            acc_d    = '0;
            dir_d    = 1'b1;
            sample_d = '0;
        end else if (tick) begin
            pre_d   = '0;
            valid_d = 1'b1;
            if (cfg.top == '0) begin
                // Degenerate amplitude: every tick closes a period.
                acc_d  = '0;
                dir_d  = 1'b1;
                pend_d = 1'b1;
            end else if (bounce) begin
                if (dir_q) begin
                    if (sum >= {1'b0, cfg.top}) begin
                        acc_d = cfg.top;
                        dir_d = 1'b0;
                    end else begin
                        acc_d = sum[DataW-1:0];
                    end
                end else if (acc_q <= step) begin
                    acc_d  = '0;
                    dir_d  = 1'b1;
                    pend_d = 1'b1;
                end else begin
                    acc_d = acc_q - step;
                end
            end else if (sum > {1'b0, cfg.top}) begin
                acc_d  = '0;
                pend_d = 1'b1;
            end else begin
                acc_d = sum[DataW-1:0];
            end
            // Square follows the post-tick direction flag.
            sample_d = (cfg.mode == MODE_SQR) ? (dir_d ? cfg.top : '0) : acc_d;
        end else if (run) begin
            pre_d = pre_q + DivW'(1);
        end
    end

    // Core state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q    <= '0;
            acc_q    <= '0;
            dir_q    <= 1'b1;
            sample_q <= '0;
            valid_q  <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            pre_q    <= pre_d;
            acc_q    <= acc_d;
            dir_q    <= dir_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            pend_q   <= pend_d;
        end
    end

    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign period_end   = pend_q;

endmodule

// File: rtl/wave_sequencer.sv
// Waveform sequencer: run/stop FSM, shadowed configuration handshake and burst counter.
module wave_sequencer
    import wave_seq_pkg::*;
#(
    parameter int unsigned DATA_W = DataW,
    parameter int unsigned DIV_W  = DivW,
    parameter int unsigned CNT_W  = CntW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [DATA_W-1:0] cfg_top,
    input  logic [DATA_W-1:0] cfg_step,
    input  logic [1:0]        cfg_mode,
    input  logic [CNT_W-1:0]  cfg_cycles,
    input  logic              start,
    input  logic              stop,
    output logic              busy,
    output logic [DATA_W-1:0] sample,
    output logic              sample_valid,
    output logic              period_end,
    output logic              done
);

    state_t          state_q, state_d;
    wave_cfg_t       active_q, active_d;
    wave_cfg_t       shadow_q, shadow_d;
    wave_cfg_t       cfg_in, cfg_eff;
    logic            pending_q, pending_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            xfer, apply, burst_hit, finish, core_clear;
    logic            core_pe;

    assign cfg_in.div    = cfg_div;
    assign cfg_in.top    = cfg_top;
    assign cfg_in.step   = cfg_step;
    assign cfg_in.mode   = mode_t'(cfg_mode);
    assign cfg_in.cycles = cfg_cycles;

    assign xfer      = cfg_valid && ready_q;
    assign burst_hit = core_pe && (active_q.cycles != '0) && (cnt_q + CNT_W'(1) == active_q.cycles);
    assign finish    = ((state_q == RUN) && burst_hit) || ((state_q == STOPPING) && core_pe);
    assign apply     = (state_q != IDLE) && core_pe && pending_q && !finish;
    // The core sees the shadow during the boundary cycle so the new period starts clean.
    assign cfg_eff    = apply ? shadow_q : active_q;
    assign core_clear = ((state_q == IDLE) && start) || finish;

    wave_ramp_core u_core (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg          (cfg_eff),
        .clear        (core_clear),
        .run          (state_q != IDLE),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_end   (core_pe)
    );

    // FSM transitions, handshake bookkeeping and period counting.
    always_comb begin
        state_d   = state_q;
        active_d  = active_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                if (xfer) begin
                    active_d = cfg_in;
                end
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end
            end
            RUN, STOPPING: begin
                if (core_pe) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (apply) begin
                    active_d  = shadow_q;
                    pending_d = 1'b0;
                    ready_d   = 1'b1;
                    cnt_d     = '0;
                end
                if (xfer) begin
                    shadow_d  = cfg_in;
                    pending_d = 1'b1;
                    ready_d   = 1'b0;
                end
                if ((state_q == RUN) && stop) begin
                    state_d = STOPPING;
                end
                // Burst end and stop end collapse into one done pulse.
                if (finish) begin
                    state_d   = IDLE;
                    done_d    = 1'b1;
                    pending_d = 1'b0;
                    ready_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            active_q  <= CfgReset;
            shadow_q  <= CfgReset;
            pending_q <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            active_q  <= active_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            cnt_q     <= cnt_d;
        end
    end

    assign cfg_ready  = ready_q;
    assign busy       = (state_q != IDLE);
    assign period_end = core_pe;
    assign done       = done_q;

endmodule

// File: tb/tb_wave_sequencer.sv
// Self-checking bench for wave_sequencer against a period-level sample model.
module tb_wave_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [15:0] cfg_div = '0;
    logic [7:0]  cfg_top = '0;
    logic [7:0]  cfg_step = '0;
    logic [1:0]  cfg_mode = '0;
    logic [15:0] cfg_cycles = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        busy;
    logic [7:0]  sample;
    logic        sample_valid;
    logic        period_end;
    logic        done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_valid = 0;
    int cur_div = 0;
    int exp_ready = -1;
    int exp_s[$];
    int exp_pe[$];

    wave_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_div      (cfg_div),
        .cfg_top      (cfg_top),
        .cfg_step     (cfg_step),
        .cfg_mode     (cfg_mode),
        .cfg_cycles   (cfg_cycles),
        .start        (start),
        .stop         (stop),
        .busy         (busy),
        .sample       (sample),
        .sample_valid (sample_valid),
        .period_end   (period_end),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void push(input int v, input int pe);
        exp_s.push_back(v);
        exp_pe.push_back(pe);
    endfunction

    // One full period of samples, derived from the ramp rules period by period.
    function automatic void push_period(input int top, input int step, input int mode);
        int s;
        int a;
        bit sq;
        s  = (step == 0) ? 1 : step;
        sq = (mode == 2);
        if (top == 0) begin
            push(0, 1);
            return;
        end
        if (mode == 1 || mode == 2) begin
            a = 0;
            while (a + s < top) begin
                a += s;
                push(sq ? top : a, 0);
            end
            push(sq ? 0 : top, 0);
            a = top;
            while (a > s) begin
                a -= s;
                push(sq ? 0 : a, 0);
            end
            push(sq ? top : 0, 1);
        end else begin
            a = 0;
            while (a + s <= top) begin
                a += s;
                push(a, 0);
            end
            push(0, 1);
        end
    endfunction

    // Walk n sample_valid pulses, checking value, period_end and tick spacing.
    task automatic consume(input int n);
        int got;
        int idle;
        got  = 0;
        idle = 0;
        while (got < n) begin
            @(negedge clk);
            if (exp_ready >= 0) check("cfg_ready_hold", cfg_ready, exp_ready);
            if (sample_valid) begin
                idle = 0;
                check("tick_gap", cyc - last_valid, cur_div + 1);
                last_valid = cyc;
                if (exp_s.size() == 0) begin
                    check("extra_sample", exp_s.size(), 1);
                    return;
                end
                check("sample", sample, exp_s.pop_front());
                check("period_end", period_end, exp_pe.pop_front());
                check("done_mid", done, 0);
                got++;
            end else begin
                check("period_end_quiet", period_end, 0);
                idle++;
                if (idle > cur_div) begin
                    check("tick_timeout", idle, cur_div);
                    return;
                end
            end
        end
    endtask

    task automatic load_and_start(input int div, input int top, input int step, input int mode,
                                  input int cycles, input bit with_stop);
        cfg_div    = 16'(div);
        cfg_top    = 8'(top);
        cfg_step   = 8'(step);
        cfg_mode   = 2'(mode);
        cfg_cycles = 16'(cycles);
        cfg_valid  = 1'b1;
        start      = 1'b1;
        stop       = with_stop;
        @(negedge clk);
        cfg_valid  = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        cur_div    = div;
        last_valid = cyc;
        check("busy_start", busy, 1);
        check("ready_start", cfg_ready, 1);
    endtask

    task automatic start_only(input int div);
        start = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        cur_div    = div;
        last_valid = cyc;
        check("busy_restart", busy, 1);
    endtask

    task automatic expect_done();
        @(negedge clk);
        check("done", done, 1);
        check("busy_after", busy, 0);
        check("sample_idle", sample, 0);
        check("ready_idle", cfg_ready, 1);
        @(negedge clk);
        check("done_pulse", done, 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_pe", period_end, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cfg_ready, 1);
    endtask

    initial begin
        int pe_cnt;
        int done_cnt;
        int found;
        int n;

        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Saw burst of two periods.
        load_and_start(0, 10, 1, 0, 2, 0);
        push_period(10, 1, 0);
        push_period(10, 1, 0);
        consume(22);
        expect_done();

        // Triangle with prescale.
        load_and_start(1, 4, 2, 1, 1, 0);
        push_period(4, 2, 1);
        consume(4);
        expect_done();

        // Square, step zero, and zero amplitude.
        load_and_start(0, 6, 2, 2, 1, 0);
        push_period(6, 2, 2);
        consume(exp_s.size());
        expect_done();
        load_and_start(0, 5, 0, 0, 1, 0);
        push_period(5, 1, 0);
        consume(6);
        expect_done();
        load_and_start(0, 0, 3, 1, 3, 0);
        repeat (3) push_period(0, 3, 1);
        consume(3);
        expect_done();

        // Mid-run reconfiguration via the shadow.
        load_and_start(0, 7, 1, 0, 0, 0);
        push_period(7, 1, 0);
        consume(3);
        cfg_top   = 8'd3;
        cfg_valid = 1'b1;
        consume(1);
        cfg_valid = 1'b0;
        check("ready_drop", cfg_ready, 0);
        exp_ready = 0;
        consume(4);
        exp_ready = 1;
        push_period(3, 1, 0);
        consume(1);
        exp_ready = -1;
        consume(3);
        stop = 1'b1;
        push_period(3, 1, 0);
        consume(1);
        stop = 1'b0;
        consume(3);
        expect_done();

        // start+stop together, then stop at sample 5 with a config that must be dropped.
        load_and_start(0, 9, 1, 0, 0, 1);
        push_period(9, 1, 0);
        consume(5);
        stop      = 1'b1;
        cfg_top   = 8'd2;
        cfg_valid = 1'b1;
        consume(1);
        stop      = 1'b0;
        cfg_valid = 1'b0;
        consume(4);
        expect_done();
        start_only(0);
        push_period(9, 1, 0);
        consume(10);
        stop = 1'b1;
        push_period(9, 1, 0);
        consume(1);
        stop = 1'b0;
        consume(9);
        expect_done();

        // Reset mid-burst, then default configuration comes back.
        load_and_start(1, 20, 3, 1, 3, 0);
        push_period(20, 3, 1);
        consume(4);
        exp_s.delete();
        exp_pe.delete();
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done_after", done, 0);
        start_only(0);
        push_period(255, 1, 0);
        consume(5);
        exp_s.delete();
        exp_pe.delete();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Continuous mode: 1000 periods with no done.
        load_and_start(0, 0, 1, 0, 0, 0);
        pe_cnt   = 0;
        done_cnt = 0;
        repeat (1000) begin
            @(negedge clk);
            if (period_end) pe_cnt++;
            if (done) done_cnt++;
        end
        check("cont_periods", pe_cnt, 1000);
        check("cont_no_done", done_cnt, 0);
        stop  = 1'b1;
        found = 0;
        for (int i = 0; i < 8 && found == 0; i++) begin
            @(negedge clk);
            stop = 1'b0;
            if (done) found = 1;
        end
        check("cont_stop_done", found, 1);
        check("cont_idle", busy, 0);
        @(negedge clk);

        // Randomized bursts.
        for (int r = 0; r < 8; r++) begin
            int d;
            int t;
            int s;
            int m;
            int c;
            d = $urandom_range(0, 2);
            t = $urandom_range(0, 30);
            s = $urandom_range(0, 6);
            m = $urandom_range(0, 3);
            c = $urandom_range(1, 3);
            load_and_start(d, t, s, m, c, 0);
            for (int p = 0; p < c; p++) push_period(t, s, m);
            n = exp_s.size();
            consume(n);
            expect_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
